// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART 8N1 receiver feeding a first-word-fall-through receive FIFO
// Sticky framing/overrun flags; the receive FSM never stalls on a full buffer.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               rx,
  input  logic                               rd_en,
  output logic [7:0]                         rd_data,
  output logic                               empty,
  output logic                               full,
  output logic [$clog2(BUFFER_SIZE+1)-1:0]   count,
  output logic                               frame_error,
  output logic                               overrun,
  input  logic                               clear_errors
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int PW           = $clog2(BUFFER_SIZE);
  localparam int NW           = $clog2(BUFFER_SIZE + 1);

  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF - 1);
  localparam logic [NW-1:0] DEPTH       = NW'(BUFFER_SIZE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rx_meta_q, rx_s_q, rx_d1_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NW-1:0] count_q, count_d;
  logic [7:0]    mem_q [BUFFER_SIZE];
  logic          frame_error_q, frame_error_d;
  logic          overrun_q, overrun_d;

  logic push_req, stop_bad, push, pop, drop;
  logic empty_w, full_w;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_d1_q && !rx_s_q) begin
          cnt_d   = HALF_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          // A start bit that is high again at mid-bit was line noise.
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = 3'd0;
            cnt_d   = BIT_RELOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = BIT_RELOAD;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (rx_s_q) push_req = 1'b1;
          else        stop_bad = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot a full-buffer push needs.
  assign pop  = rd_en && !empty_w;
  assign push = push_req && (!full_w || pop);
  assign drop = push_req && !push;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    frame_error_d = stop_bad | (frame_error_q & ~clear_errors);
    overrun_d     = drop | (overrun_q & ~clear_errors);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      rx_d1_q       <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      shift_q       <= 8'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < BUFFER_SIZE; i++) mem_q[i] <= 8'd0;
    end else begin
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      rx_d1_q       <= rx_s_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      count_q       <= count_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      if (push) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign empty       = empty_w;
  assign full        = full_w;
  assign count       = count_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for uart_rx_fifo at 10 clocks per bit
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       rd_en;
  logic       clear_errors;
  logic [7:0] rd_data;
  logic       empty, full, frame_error, overrun;
  logic [4:0] count;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLOCK_FREQ (1000000),
    .BAUD_RATE  (100000),
    .BUFFER_SIZE(16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .frame_error (frame_error),
    .overrun     (overrun),
    .clear_errors(clear_errors)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop bit is driven at negedge 90 of the frame; the DUT samples it in
  // the cycle after the 7th following negedge, so rd_en lands in the push cycle.
  task automatic send(input logic [7:0] b, input logic stop_bit, input logic pop_at_push);
    rx = 1'b0;
    idle(10);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      idle(10);
    end
    rx = stop_bit;
    if (pop_at_push) begin
      idle(7);
      rd_en = 1'b1;
      idle(1);
      rd_en = 1'b0;
      idle(2);
    end else begin
      idle(10);
    end
    rx = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'h00);
    chk({tag, "_empty"},   32'(empty), 32'd1);
    chk({tag, "_full"},    32'(full), 32'd0);
    chk({tag, "_count"},   32'(count), 32'd0);
    chk({tag, "_ferr"},    32'(frame_error), 32'd0);
    chk({tag, "_ovr"},     32'(overrun), 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    rx           = 1'b1;
    rd_en        = 1'b0;
    clear_errors = 1'b0;
    idle(3);
    chk_reset_state("rst");
    reset_n = 1'b1;
    idle(5);

    // single byte
    send(8'hA5, 1'b1, 1'b0);
    idle(2);
    chk("t1_empty", 32'(empty), 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_data",  32'(rd_data), 32'hA5);
    pop();
    chk("t1_empty_after", 32'(empty), 32'd1);
    chk("t1_count_after", 32'(count), 32'd0);
    chk("t1_ferr", 32'(frame_error), 32'd0);
    chk("t1_ovr",  32'(overrun), 32'd0);

    // back-to-back frames
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    idle(2);
    chk("t2_count", 32'(count), 32'd3);
    chk("t2_rd0", 32'(rd_data), 32'h00);
    pop();
    chk("t2_rd1", 32'(rd_data), 32'hFF);
    pop();
    chk("t2_rd2", 32'(rd_data), 32'h3C);
    pop();
    chk("t2_empty", 32'(empty), 32'd1);

    // short low glitch must not start a frame
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    chk("t3_count", 32'(count), 32'd0);
    chk("t3_ferr",  32'(frame_error), 32'd0);
    chk("t3_ovr",   32'(overrun), 32'd0);
    send(8'h55, 1'b1, 1'b0);
    idle(2);
    chk("t3_count2", 32'(count), 32'd1);
    chk("t3_data",   32'(rd_data), 32'h55);
    pop();

    // framing error
    send(8'h81, 1'b0, 1'b0);
    idle(5);
    chk("t4_ferr",  32'(frame_error), 32'd1);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_ovr",   32'(overrun), 32'd0);
    clear_errors = 1'b1;
    idle(1);
    clear_errors = 1'b0;
    chk("t4_ferr_clr", 32'(frame_error), 32'd0);

    // overflow: 17 frames into a 16-deep buffer
    for (int i = 1; i <= 17; i++) send(8'(i), 1'b1, 1'b0);
    idle(2);
    chk("t5_full",  32'(full), 32'd1);
    chk("t5_count", 32'(count), 32'd16);
    chk("t5_ovr",   32'(overrun), 32'd1);
    chk("t5_head",  32'(rd_data), 32'h01);
    chk("t5_ferr",  32'(frame_error), 32'd0);
    for (int i = 0; i < 16; i++) pop();
    clear_errors = 1'b1;
    idle(1);
    clear_errors = 1'b0;
    chk("t5_empty_drained", 32'(empty), 32'd1);
    chk("t5_ovr_clr", 32'(overrun), 32'd0);

    // 17th push coincides with a pop
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b1, 1'b0);
    send(8'h11, 1'b1, 1'b1);
    idle(2);
    chk("t5b_ovr",   32'(overrun), 32'd0);
    chk("t5b_count", 32'(count), 32'd16);
    chk("t5b_full",  32'(full), 32'd1);
    chk("t5b_head",  32'(rd_data), 32'h02);
    for (int i = 0; i < 15; i++) pop();
    chk("t5b_last", 32'(rd_data), 32'h11);
    pop();
    chk("t5b_empty", 32'(empty), 32'd1);

    // reset mid-frame with a byte already buffered
    send(8'h99, 1'b1, 1'b0);
    idle(2);
    chk("t6_pre_count", 32'(count), 32'd1);
    rx = 1'b0;
    idle(10);
    for (int k = 0; k < 4; k++) begin
      rx = k[0] ? 1'b1 : 1'b0;
      idle(10);
    end
    reset_n = 1'b0;
    idle(2);
    chk_reset_state("t6");
    rx = 1'b1;
    idle(1);
    reset_n = 1'b1;
    idle(5);
    send(8'h42, 1'b1, 1'b0);
    idle(2);
    chk("t6_count", 32'(count), 32'd1);
    chk("t6_data",  32'(rd_data), 32'h42);
    chk("t6_ferr",  32'(frame_error), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
